// File: rtl/pwm_capture.sv
// pwm_capture: multi-channel PWM period/high-time capture with a
// per-channel holding slot, round-robin valid/ready result port and sticky irq.
// Ports: clk_i, rst_i (async, active high), en_i, pwm_i[NUM_CH],
//   res_valid_o/res_ready_i, res_ch_o, res_period_o, res_high_o, res_sat_o,
//   irq_o, irq_clr_i.
module pwm_capture #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [NUM_CH-1:0]    pwm_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [CW-1:0]        res_ch_o,
  output logic [CNT_WIDTH-1:0] res_period_o,
  output logic [CNT_WIDTH-1:0] res_high_o,
  output logic                 res_sat_o,
  output logic                 irq_o,
  input  logic                 irq_clr_i
);

  typedef enum logic {IDLE, MEAS} st_t;

  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s, prev_q, rise_q, fall_q;

  assign s = sync_q[SYNC_STAGES-1];

  // Edge pulses are registered so every channel event sees the
  // same fixed pipeline delay from the pin.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q[0] <= pwm_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= s;
      rise_q <= s & ~prev_q;
      fall_q <= ~s & prev_q;
    end
  end

  st_t                  st_q   [NUM_CH];
  st_t                  st_d   [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d  [NUM_CH];
  logic [CNT_WIDTH-1:0] high_q [NUM_CH];
  logic [CNT_WIDTH-1:0] high_d [NUM_CH];
  logic [CNT_WIDTH-1:0] wr_high[NUM_CH];
  logic [NUM_CH-1:0]    fell_q, fell_d, sat_q, sat_d, wr;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c]   = st_q[c];
      cnt_d[c]  = cnt_q[c];
      high_d[c] = high_q[c];
      fell_d[c] = fell_q[c];
      sat_d[c]  = sat_q[c];
      wr[c]     = 1'b0;
      // no falling edge this period: input stuck high
      wr_high[c] = fell_q[c] ? high_q[c] : cnt_q[c];
      if (!en_i) begin
        st_d[c]   = IDLE;
        cnt_d[c]  = '0;
        fell_d[c] = 1'b0;
        sat_d[c]  = 1'b0;
      end else begin
        unique case (st_q[c])
          IDLE: begin
            cnt_d[c] = '0;
            if (rise_q[c]) begin
              st_d[c]   = MEAS;
              cnt_d[c]  = ONE;
              fell_d[c] = 1'b0;
              sat_d[c]  = 1'b0;
            end
          end
          MEAS: begin
            if (rise_q[c]) begin
              wr[c]     = 1'b1;
              cnt_d[c]  = ONE;
              fell_d[c] = 1'b0;
              sat_d[c]  = 1'b0;
            end else begin
              if (cnt_q[c] == CMAX) sat_d[c] = 1'b1;
              else cnt_d[c] = cnt_q[c] + ONE;
              if (fall_q[c]) begin
                high_d[c] = cnt_q[c];
                fell_d[c] = 1'b1;
              end
            end
          end
          default: st_d[c] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= IDLE;
        cnt_q[c]  <= '0;
        high_q[c] <= '0;
      end
      fell_q <= '0;
      sat_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= st_d[c];
        cnt_q[c]  <= cnt_d[c];
        high_q[c] <= high_d[c];
      end
      fell_q <= fell_d;
      sat_q  <= sat_d;
    end
  end

  logic [CNT_WIDTH-1:0] slot_per  [NUM_CH];
  logic [CNT_WIDTH-1:0] slot_high [NUM_CH];
  logic [NUM_CH-1:0]    slot_sat, pend_q, ovr;
  logic [CW-1:0]        ptr_q, sel;
  logic                 found, load, irq_set;
  int                   j;

  // ptr_q holds the first channel to consider, i.e. one past
  // the last channel served.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && pend_q[j]) begin
        found = 1'b1;
        sel   = CW'(j);
      end
    end
  end

  assign load = found & (~res_valid_o | res_ready_i);

  // A write that coincides with a load of the same slot loses nothing.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      ovr[c] = wr[c] & pend_q[c] & ~(load && sel == CW'(c));
  end

  assign irq_set = (|ovr) | (load & slot_sat[sel]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        slot_per[c]  <= '0;
        slot_high[c] <= '0;
      end
      slot_sat <= '0;
      pend_q   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!en_i) begin
          pend_q[c] <= 1'b0;
        end else if (wr[c]) begin
          slot_per[c]  <= cnt_q[c];
          slot_high[c] <= wr_high[c];
          slot_sat[c]  <= sat_q[c];
          pend_q[c]    <= 1'b1;
        end else if (load && sel == CW'(c)) begin
          pend_q[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_o  <= 1'b0;
      res_ch_o     <= '0;
      res_period_o <= '0;
      res_high_o   <= '0;
      res_sat_o    <= 1'b0;
      ptr_q        <= '0;
      irq_o        <= 1'b0;
    end else begin
      if (load) begin
        res_valid_o  <= 1'b1;
        res_ch_o     <= sel;
        res_period_o <= slot_per[sel];
        res_high_o   <= slot_high[sel];
        res_sat_o    <= slot_sat[sel];
        ptr_q <= (sel == CW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
      end else if (res_valid_o && res_ready_i) begin
        res_valid_o <= 1'b0;
      end
      if (irq_set) irq_o <= 1'b1;
      else if (irq_clr_i) irq_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed vectors and corner-case sequences for
// pwm_capture (NUM_CH=4, CNT_WIDTH=8, SYNC_STAGES=2).
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst, en, ready, irq_clr;
  logic [3:0] pwm;
  logic       valid, sat, irq;
  logic [1:0] ch;
  logic [7:0] per, high;

  pwm_capture #(
    .NUM_CH(4),
    .CNT_WIDTH(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .en_i(en),
    .pwm_i(pwm),
    .res_valid_o(valid),
    .res_ready_i(ready),
    .res_ch_o(ch),
    .res_period_o(per),
    .res_high_o(high),
    .res_sat_o(sat),
    .irq_o(irq),
    .irq_clr_i(irq_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] run = '0;
  logic [3:0] man = '0;
  int gper[4] = '{default: 10};
  int ghi[4]  = '{default: 1};
  int ph[4]   = '{default: 0};

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (run[c]) begin
        pwm[c] = (ph[c] < ghi[c]);
        ph[c]  = (ph[c] + 1 >= gper[c]) ? 0 : ph[c] + 1;
      end else begin
        pwm[c] = man[c];
        ph[c]  = 0;
      end
    end
  end

  typedef struct {
    int ch; int per; int hi; int sat; int cyc;
  } res_t;
  res_t q[$];

  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1)
      q.push_back('{int'(ch), int'(per), int'(high), int'(sat), cyc});
  end

  typedef struct {
    int ch; int per; int hi;
    int e_per; int e_hi; int e_sat; int e_irq;
  } vec_t;
  vec_t vt[7];

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input int i, input int e_ch,
                         input int e_per, input int e_hi, input int e_sat);
    res_t r;
    r = '{-1, -1, -1, -1, 0};
    if (i < q.size()) r = q[i];
    check({nm, ".ch"}, r.ch, e_ch);
    check({nm, ".per"}, r.per, e_per);
    check({nm, ".high"}, r.hi, e_hi);
    check({nm, ".sat"}, r.sat, e_sat);
  endtask

  task automatic wait_res(input string nm, input int n, input int budget);
    int k;
    k = 0;
    while (q.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d results expected %0d",
               nm, q.size(), n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = '0;
    man = '0;
    en = 1'b0;
    ready = 1'b0;
    irq_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
  endtask

  // Called just after a posedge; h cycles sampled high, l low.
  task automatic man_pulse(input int c, input int h, input int l);
    man[c] = 1'b1;
    repeat (h) @(posedge clk);
    #1 man[c] = 1'b0;
    repeat (l) @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0] = '{0, 10, 3, 10, 3, 0, 0};
    vt[1] = '{1, 8, 4, 8, 4, 0, 0};
    vt[2] = '{3, 50, 49, 50, 49, 0, 0};
    vt[3] = '{2, 300, 100, 255, 100, 1, 1};
    vt[4] = '{1, 7, 1, 7, 1, 0, 0};
    vt[5] = '{2, 255, 254, 255, 254, 0, 0};
    vt[6] = '{0, 256, 128, 255, 128, 1, 1};

    rst = 1'b1;
    en = 1'b0;
    ready = 1'b0;
    irq_clr = 1'b0;
    pwm = '0;
    #1;
    check("rst.valid", int'(valid), 0);
    check("rst.irq", int'(irq), 0);
    check("rst.ch", int'(ch), 0);
    check("rst.period", int'(per), 0);
    check("rst.high", int'(high), 0);
    check("rst.sat", int'(sat), 0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      gper[vt[v].ch] = vt[v].per;
      ghi[vt[v].ch]  = vt[v].hi;
      en = 1'b1;
      ready = 1'b1;
      run[vt[v].ch] = 1'b1;
      wait_res($sformatf("vec%0d", v), 2, 3 * vt[v].per + 20);
      for (int r = 0; r < 2; r++)
        chk_res($sformatf("vec%0d.r%0d", v, r), r, vt[v].ch,
                vt[v].e_per, vt[v].e_hi, vt[v].e_sat);
      check($sformatf("vec%0d.irq", v), int'(irq), vt[v].e_irq);
      run = '0;
    end

    // latency from the completing rising edge
    do_reset();
    en = 1'b1;
    @(posedge clk); #1;
    man_pulse(0, 5, 5);
    man[0] = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 check("lat.early", int'(valid), 0);
    @(posedge clk);
    #1 check("lat.valid", int'(valid), 1);
    check("lat.period", int'(per), 10);
    check("lat.high", int'(high), 5);

    // ready low: output held, overrun sets irq, clear
    do_reset();
    gper[1] = 8;
    ghi[1]  = 4;
    en = 1'b1;
    run[1] = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("hold.valid1", int'(valid), 1);
    check("hold.irq_pre", int'(irq), 0);
    repeat (20) @(posedge clk);
    #1 run = '0;
    repeat (6) @(posedge clk);
    #1 check("hold.valid2", int'(valid), 1);
    check("hold.ch", int'(ch), 1);
    check("hold.period", int'(per), 8);
    check("hold.high", int'(high), 4);
    check("ovr.irq", int'(irq), 1);
    irq_clr = 1'b1;
    @(posedge clk);
    #1 irq_clr = 1'b0;
    check("ovr.irq_clr", int'(irq), 0);
    ready = 1'b1;
    wait_res("ovr.drain", 2, 10);
    chk_res("ovr.r0", 0, 1, 8, 4, 0);
    chk_res("ovr.r1", 1, 1, 8, 4, 0);
    repeat (3) @(posedge clk);
    #1 check("ovr.empty", int'(valid), 0);
    check("ovr.count", q.size(), 2);

    // in-phase channels: round robin on consecutive cycles
    do_reset();
    for (int c = 0; c < 4; c++) begin
      gper[c] = 20;
      ghi[c]  = 5;
    end
    en = 1'b1;
    ready = 1'b1;
    run = 4'hf;
    wait_res("rr", 8, 80);
    for (int i = 0; i < 8; i++)
      chk_res($sformatf("rr%0d", i), i, i % 4, 20, 5, 0);
    for (int i = 1; i < 4; i++)
      if (i < q.size())
        check($sformatf("rr.gap%0d", i), q[i].cyc - q[i-1].cyc, 1);
    check("rr.irq", int'(irq), 0);
    run = '0;

    // saturation, then a normal period
    do_reset();
    en = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    man_pulse(2, 100, 200);
    man_pulse(2, 50, 50);
    man_pulse(2, 1, 5);
    wait_res("sat", 2, 20);
    chk_res("sat.r0", 0, 2, 255, 100, 1);
    chk_res("sat.r1", 1, 2, 100, 50, 0);
    check("sat.irq", int'(irq), 1);

    // en dropped mid-period
    do_reset();
    en = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    man_pulse(0, 3, 7);
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1 en = 1'b1;
    check("en.none_off", q.size(), 0);
    man_pulse(0, 3, 7);
    check("en.none_first", q.size(), 0);
    man_pulse(0, 3, 7);
    check("en.count", q.size(), 1);
    chk_res("en.r0", 0, 0, 10, 3, 0);

    // async reset during a handshake
    do_reset();
    en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) man_pulse(0, 3, 7);
    check("arst.pre_valid", int'(valid), 1);
    check("arst.pre_irq", int'(irq), 1);
    ready = 1'b1;
    #2 rst = 1'b1;
    #1 check("arst.valid", int'(valid), 0);
    check("arst.irq", int'(irq), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
